// File: rtl/up_down_counter.sv
// up_down_counter
//
// Loadable up/down binary counter. It is a leaf datapath block that holds a
// single WIDTH-bit count register. Each rising clock edge applies one of four
// actions in strict priority: parallel load, increment, decrement, or hold.
// Arithmetic is unsigned and wraps modulo 2^WIDTH. There is no saturation and
// there are no flag outputs.
//
// Parameters:
//   WIDTH    - bit width of data_in / data_out (default 8)
//
// Ports:
//   clk      - in,  1     : single clock; all state updates on its rising edge
//   reset    - in,  1     : asynchronous active-low reset; low clears the count
//                           immediately and masks every clock edge
//   data_in  - in,  WIDTH : parallel load value, sampled only while load = 1
//   load     - in,  1     : synchronous load request; overrides enable/up_down
//   enable   - in,  1     : count enable
//   up_down  - in,  1     : count direction, 1 = increment, 0 = decrement
//   data_out - out, WIDTH : current count, driven straight from the register
//
// Handshake: none. Every input is sampled at each rising edge of clk. The
// effect of an edge is visible on data_out after that edge, before the next
// one.

module up_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] count;

  // Width-matched unit step. Using a sized constant keeps the add and the
  // subtract at WIDTH bits, so they wrap naturally.
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      // A load overrides counting, so no extra +/-1 is applied.
      count <= data_in;
    end else if (enable) begin
      if (up_down) begin
        count <= count + ONE;
      end else begin
        count <= count - ONE;
      end
    end
  end

  // The output has no combinational path from any input.
  assign data_out = count;

endmodule

// File: tb/tb_up_down_counter.sv
module tb_up_down_counter;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load;
  logic         enable;
  logic         up_down;
  logic [W-1:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  up_down_counter #(.WIDTH(W)) counter (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .enable   (enable),
    .up_down  (up_down),
    .data_out (data_out)
  );

  // Clock and reset: 20 ns period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change on the falling edge. One rising edge is then applied, and
  // the outputs are sampled at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    n_checks++;
    assert (data_out === exp) n_pass++;
    else $error("FAIL %s: data_out=0x%02h expected=0x%02h", tag, data_out, exp);
  endtask

  task automatic drive(input logic l, input logic e, input logic ud,
                       input logic [W-1:0] d);
    load    = l;
    enable  = e;
    up_down = ud;
    data_in = d;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    @(negedge clk);

    // Held in reset while enabled: the count stays at zero.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", 8'h00);
    end

    // Release reset, then load with enable also high: load wins.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'd10);
    step();
    check("load_10", 8'd10);

    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step(); check("up_11", 8'd11);
    step(); check("up_12", 8'd12);
    step(); check("up_13", 8'd13);
    step(); check("up_14", 8'd14);
    step(); check("up_15", 8'd15);

    // Asynchronous reset in the middle of counting: load 0x05, then pull
    // reset low between edges.
    drive(1'b1, 1'b0, 1'b1, 8'h05);
    step();
    check("pre_reset_05", 8'h05);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    #5 reset = 1'b0;
    #1 check("async_reset", 8'h00);

    // Pending load while in reset is discarded.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    step();
    check("reset_blocks_load", 8'h00);
    reset = 1'b1;

    // Down count with wrap below zero.
    drive(1'b1, 1'b0, 1'b0, 8'h02);
    step(); check("load_02", 8'h02);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step(); check("down_01", 8'h01);
    step(); check("down_00", 8'h00);
    step(); check("down_ff", 8'hFF);
    step(); check("down_fe", 8'hFE);

    // Up count with wrap past all-ones.
    drive(1'b1, 1'b0, 1'b1, 8'hFE);
    step(); check("load_fe", 8'hFE);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step(); check("up_ff", 8'hFF);
    step(); check("up_00", 8'h00);
    step(); check("up_01", 8'h01);

    // Hold: with no enable and no load, up_down and data_in are ignored.
    drive(1'b1, 1'b0, 1'b1, 8'h3C);
    step(); check("load_3c", 8'h3C);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, i[0], 8'(i * 37 + 1));
      step();
      check("hold_3c", 8'h3C);
    end

    // Priority and direction switch.
    drive(1'b1, 1'b0, 1'b1, 8'h20);
    step(); check("load_20", 8'h20);
    drive(1'b1, 1'b1, 1'b0, 8'h80);
    step(); check("load_beats_enable", 8'h80);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step(); check("switch_up_81", 8'h81);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step(); check("switch_down_80", 8'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
